// File: rtl/vga_frame_monitor.sv
// Passive VGA timing checker: measures hs/vs periods and widths against XGA timing,
// accumulates a per-frame pixel checksum and reports lock and sticky error status.
module vga_frame_monitor #(
  parameter int   H_TOTAL  = 1344,
  parameter int   V_TOTAL  = 806,
  parameter int   HS_WIDTH = 136,
  parameter int   VS_WIDTH = 8064,
  parameter logic SYNC_POL = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hs,
  input  logic        vs,
  input  logic [3:0]  r,
  input  logic [3:0]  g,
  input  logic [3:0]  b,
  output logic        frame_valid,
  output logic [15:0] frame_sig,
  output logic [15:0] frame_count,
  output logic [15:0] line_len,
  output logic [15:0] lines,
  output logic [3:0]  err,
  output logic        locked
);

  // state     | meaning
  // SYNC_WAIT | idle until the first vs rise
  // MEASURE   | checks active, waiting for one clean frame
  // LOCKED    | checks active, timing matched for a full frame
  typedef enum logic [1:0] {SYNC_WAIT, MEASURE, LOCKED} state_t;

  state_t state, state_nx;

  logic        hs_q, hs_qq, vs_q, vs_qq;
  logic [11:0] pix_q;
  logic        hs_rise, hs_fall, vs_rise, vs_fall;
  logic [15:0] line_cnt, hsw_cnt, vsw_cnt, hs_num, acc;
  logic        have_ref, first_vs, frame_err;
  logic        pend_valid;
  logic [15:0] pend_sig, pend_lines;
  logic        active;
  logic [3:0]  err_now;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign hs_rise = (hs_q == SYNC_POL) && (hs_qq != SYNC_POL);
  assign hs_fall = (hs_q != SYNC_POL) && (hs_qq == SYNC_POL);
  assign vs_rise = (vs_q == SYNC_POL) && (vs_qq != SYNC_POL);
  assign vs_fall = (vs_q != SYNC_POL) && (vs_qq == SYNC_POL);
  assign active  = (state != SYNC_WAIT);
  assign locked  = (state == LOCKED);

  always_comb begin
    err_now    = 4'b0000;
    err_now[0] = active && hs_rise && have_ref && (line_cnt != 16'(H_TOTAL));
    // a partial hs pulse straddling the SYNC_WAIT exit cannot be measured
    err_now[1] = active && hs_fall && have_ref && (hsw_cnt != 16'(HS_WIDTH));
    err_now[2] = active && vs_rise && !first_vs && (hs_num != 16'(V_TOTAL));
    err_now[3] = active && vs_fall && (vsw_cnt != 16'(VS_WIDTH));
  end

  always_comb begin
    state_nx = state;
    case (state)
      SYNC_WAIT: if (vs_rise) state_nx = MEASURE;
      MEASURE:   if (vs_rise && !frame_err && (err_now == 4'b0000)) state_nx = LOCKED;
      LOCKED:    if (err_now != 4'b0000) state_nx = MEASURE;
      default:   state_nx = SYNC_WAIT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= SYNC_WAIT;
    else     state <= state_nx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hs_q        <= 1'b0;
      hs_qq       <= 1'b0;
      vs_q        <= 1'b0;
      vs_qq       <= 1'b0;
      pix_q       <= 12'h000;
      line_cnt    <= 16'h0000;
      hsw_cnt     <= 16'h0000;
      vsw_cnt     <= 16'h0000;
      hs_num      <= 16'h0000;
      acc         <= 16'h0000;
      have_ref    <= 1'b0;
      first_vs    <= 1'b0;
      frame_err   <= 1'b0;
      pend_valid  <= 1'b0;
      pend_sig    <= 16'h0000;
      pend_lines  <= 16'h0000;
      frame_valid <= 1'b0;
      frame_sig   <= 16'h0000;
      frame_count <= 16'h0000;
      line_len    <= 16'h0000;
      lines       <= 16'h0000;
      err         <= 4'b0000;
    end else begin
      hs_q  <= hs;
      vs_q  <= vs;
      pix_q <= {r, g, b};
      hs_qq <= hs_q;
      vs_qq <= vs_q;

      line_cnt <= hs_rise ? 16'd1 : sat_inc(line_cnt);
      if (hs_rise)                hsw_cnt <= 16'd1;
      else if (hs_q == SYNC_POL)  hsw_cnt <= sat_inc(hsw_cnt);
      if (vs_rise)                vsw_cnt <= 16'd1;
      else if (vs_q == SYNC_POL)  vsw_cnt <= sat_inc(vsw_cnt);

      acc <= acc + {4'h0, pix_q};

      // publish is staged one cycle so frame_* land together with frame_valid
      pend_valid  <= 1'b0;
      frame_valid <= pend_valid;
      if (pend_valid) begin
        frame_sig   <= pend_sig;
        lines       <= pend_lines;
        frame_count <= sat_inc(frame_count);
      end

      err <= err | err_now;

      if (state == SYNC_WAIT) begin
        have_ref <= 1'b0;
        if (vs_rise) begin
          acc       <= {4'h0, pix_q};
          hs_num    <= 16'h0000;
          first_vs  <= 1'b1;
          frame_err <= 1'b0;
        end
      end else begin
        if (hs_rise) begin
          have_ref <= 1'b1;
          if (have_ref) line_len <= line_cnt;
        end
        if (vs_rise) begin
          acc        <= {4'h0, pix_q};
          pend_valid <= 1'b1;
          pend_sig   <= acc;
          pend_lines <= hs_num;
          hs_num     <= hs_rise ? 16'd1 : 16'd0;
          first_vs   <= 1'b0;
          frame_err  <= 1'b0;
        end else begin
          if (hs_rise) hs_num <= sat_inc(hs_num);
          frame_err <= frame_err | (err_now != 4'b0000);
        end
      end
    end
  end

endmodule

// File: tb/tb_vga_frame_monitor.sv
// Directed bench for vga_frame_monitor using a reduced 40x12 raster
// (hs 6 clocks at column 30, vs 2 lines from line 9) to keep runs short.
module tb_vga_frame_monitor;

  localparam int HT  = 40;
  localparam int VT  = 12;
  localparam int HSW = 6;
  localparam int VSW = 2 * HT;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        hs = 1'b0, vs = 1'b0;
  logic [3:0]  r = 4'h0, g = 4'h0, b = 4'h0;
  logic        frame_valid;
  logic [15:0] frame_sig, frame_count, line_len, lines;
  logic [3:0]  err;
  logic        locked;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int vs_cyc = 0;
  int fv_cnt = 0;
  int fv_lat = 0;
  int err0_cyc = -1;
  int unlock_cyc = -2;
  logic err0_prev = 1'b0;
  logic locked_prev = 1'b0;
  int fv_base;

  vga_frame_monitor #(
    .H_TOTAL(HT), .V_TOTAL(VT), .HS_WIDTH(HSW), .VS_WIDTH(VSW), .SYNC_POL(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .hs(hs), .vs(vs), .r(r), .g(g), .b(b),
    .frame_valid(frame_valid), .frame_sig(frame_sig), .frame_count(frame_count),
    .line_len(line_len), .lines(lines), .err(err), .locked(locked)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  always @(negedge clk) begin
    if (frame_valid) begin
      fv_cnt = fv_cnt + 1;
      fv_lat = cyc - vs_cyc;
    end
    if (err[0] && !err0_prev) err0_cyc = cyc;
    if (!locked && locked_prev) unlock_cyc = cyc;
    err0_prev   = err[0];
    locked_prev = locked;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (got !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // One raster frame; short_line is 39 clocks, narrow_line has a 5-clock hs.
  task automatic drive_frame(input int nlines, input int short_line, input int narrow_line,
                             input int vs_lines, input logic [11:0] pix);
    int len, w;
    logic vs_new;
    for (int l = 0; l < nlines; l++) begin
      len = (l == short_line) ? HT - 1 : HT;
      w   = (l == narrow_line) ? HSW - 1 : HSW;
      for (int c = 0; c < len; c++) begin
        @(posedge clk);
        #1;
        hs     = (c >= 30) && (c < 30 + w);
        vs_new = (l >= 9) && (l < 9 + vs_lines);
        if (vs_new && !vs) vs_cyc = cyc;
        vs = vs_new;
        {r, g, b} = pix;
      end
    end
  endtask

  initial begin
    #2;
    chk("rst_frame_valid", {31'd0, frame_valid}, 32'd0);
    chk("rst_frame_sig", {16'd0, frame_sig}, 32'd0);
    chk("rst_frame_count", {16'd0, frame_count}, 32'd0);
    chk("rst_line_len", {16'd0, line_len}, 32'd0);
    chk("rst_lines", {16'd0, lines}, 32'd0);
    chk("rst_err", {28'd0, err}, 32'd0);
    chk("rst_locked", {31'd0, locked}, 32'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // ideal frames, white
    drive_frame(VT, -1, -1, 2, 12'hFFF);
    chk("f0_no_publish", fv_cnt, 0);
    chk("f0_locked", {31'd0, locked}, 32'd0);
    drive_frame(VT, -1, -1, 2, 12'hFFF);
    drive_frame(VT, -1, -1, 2, 12'hFFF);
    chk("ideal_pulses", fv_cnt, 2);
    chk("ideal_latency", fv_lat, 3);
    chk("ideal_sig", {16'd0, frame_sig}, 32'h0000FE20);
    chk("ideal_lines", {16'd0, lines}, VT);
    chk("ideal_line_len", {16'd0, line_len}, HT);
    chk("ideal_locked", {31'd0, locked}, 32'd1);
    chk("ideal_err", {28'd0, err}, 32'd0);
    chk("ideal_count", {16'd0, frame_count}, 32'd2);

    // black frames
    drive_frame(VT, -1, -1, 2, 12'h000);
    drive_frame(VT, -1, -1, 2, 12'h000);
    chk("black_sig", {16'd0, frame_sig}, 32'd0);
    chk("black_count", {16'd0, frame_count}, 32'd4);

    // constant 0x123
    drive_frame(VT, -1, -1, 2, 12'h123);
    drive_frame(VT, -1, -1, 2, 12'h123);
    chk("c123_sig", {16'd0, frame_sig}, 32'h000021A0);
    chk("c123_locked", {31'd0, locked}, 32'd1);

    // one 39-clock line
    drive_frame(VT, 3, -1, 2, 12'hFFF);
    chk("short_err", {28'd0, err}, 32'b0001);
    chk("short_locked", {31'd0, locked}, 32'd0);
    chk("short_unlock_same_clk", unlock_cyc, err0_cyc);
    drive_frame(VT, -1, -1, 2, 12'hFFF);
    chk("relock_locked", {31'd0, locked}, 32'd1);
    chk("relock_err_sticky", {28'd0, err}, 32'b0001);

    // 11-line frame
    drive_frame(VT - 1, -1, -1, 2, 12'hFFF);
    drive_frame(VT, -1, -1, 2, 12'hFFF);
    chk("lines_err", {28'd0, err}, 32'b0101);
    chk("lines_value", {16'd0, lines}, VT - 1);
    chk("lines_locked", {31'd0, locked}, 32'd0);
    drive_frame(VT, -1, -1, 2, 12'hFFF);
    chk("lines_relock", {31'd0, locked}, 32'd1);

    // 5-clock hs pulse
    drive_frame(VT, -1, 2, 2, 12'hFFF);
    chk("hsw_err", {28'd0, err}, 32'b0111);
    chk("hsw_locked", {31'd0, locked}, 32'd0);
    drive_frame(VT, -1, -1, 2, 12'hFFF);

    // 1-line vs pulse
    drive_frame(VT, -1, -1, 1, 12'hFFF);
    chk("vsw_err", {28'd0, err}, 32'b1111);
    chk("vsw_locked", {31'd0, locked}, 32'd0);
    drive_frame(VT, -1, -1, 2, 12'hFFF);
    drive_frame(VT, -1, -1, 2, 12'hFFF);

    // reset in the middle of a locked frame
    drive_frame(5, -1, -1, 2, 12'hFFF);
    chk("pre_rst_locked", {31'd0, locked}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_count", {16'd0, frame_count}, 32'd0);
    chk("mid_rst_sig", {16'd0, frame_sig}, 32'd0);
    chk("mid_rst_err", {28'd0, err}, 32'd0);
    chk("mid_rst_locked", {31'd0, locked}, 32'd0);
    chk("mid_rst_lines", {16'd0, lines}, 32'd0);
    chk("mid_rst_line_len", {16'd0, line_len}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    hs = 1'b0;
    vs = 1'b0;
    fv_base = fv_cnt;
    drive_frame(VT, -1, -1, 2, 12'hFFF);
    chk("post_rst_no_publish", fv_cnt - fv_base, 0);
    drive_frame(VT, -1, -1, 2, 12'hFFF);
    chk("post_rst_pulses", fv_cnt - fv_base, 1);
    chk("post_rst_count", {16'd0, frame_count}, 32'd1);
    chk("post_rst_sig", {16'd0, frame_sig}, 32'h0000FE20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vga_frame_monitor.md
Name: vga_frame_monitor

Overview:
- Passive checker on the VGA output of top_vga, on the same pixel clock as tiff_writer.
- Measures hs/vs timing against XGA 1024x768@60 (1344x806 total).
- Computes a 16-bit per-frame pixel checksum and reports lock and error status.
- Used in simulation benches and as an on-chip debug probe; never drives the display path.

Parameters:
H_TOTAL, 1344, expected pixel clocks between consecutive hs assertions
V_TOTAL, 806, expected hs assertions per frame
HS_WIDTH, 136, expected hs active width in clocks
VS_WIDTH, 8064, expected vs active width in clocks (6 lines x H_TOTAL)
SYNC_POL, 1'b1, active level of hs and vs

Ports:
clk  in  1  pixel clock (65 MHz)
rst  in  1  asynchronous, active-high reset
hs  in  1  horizontal sync from top_vga
vs  in  1  vertical sync from top_vga
r  in  4  red
g  in  4  green
b  in  4  blue
frame_valid  out  1  one-cycle pulse; frame_* outputs updated
frame_sig  out  16  checksum of last complete frame
frame_count  out  16  complete frames seen since reset, saturating
line_len  out  16  last measured hs-to-hs period
lines  out  16  hs assertions in last complete frame
err  out  4  sticky flags: [0] line_len, [1] hs_width, [2] frame_lines, [3] vs_width
locked  out  1  timing matched for at least one full frame

Behaviour:
- Reset: all outputs 0; state SYNC_WAIT; all counters and accumulator cleared.
- Input stage: hs, vs and rgb are registered once (_q), then hs/vs once more (_qq).
- Edge definitions:
  - Rise: _q == SYNC_POL and _qq != SYNC_POL.
  - Fall: the opposite.
- Internal 16-bit counters saturate at 0xFFFF: clk-since-hs-rise, hs-active width, vs-active width, hs count.
- Checksum: acc <= acc + {r_q,g_q,b_q} mod 2^16 every cycle, including blanking.
- States:
  - SYNC_WAIT: ignore everything until the first vs rise, then go to MEASURE with acc = current pixel, hs count = 0, no line reference.
  - MEASURE: checks active. At a vs rise with no err bit set during the frame just ended, go to LOCKED.
  - LOCKED: checks active. Any check failure sets its err bit, drops locked, and returns to MEASURE.
- Checks (MEASURE and LOCKED only):
  - hs rise with a prior hs rise seen since leaving SYNC_WAIT: line_len <= count; count != H_TOTAL sets err[0].
  - hs fall: width != HS_WIDTH sets err[1].
  - vs rise: hs count != V_TOTAL sets err[2]. Skipped on the first vs rise after SYNC_WAIT.
  - vs fall: width != VS_WIDTH sets err[3].
- Frame publish: on each vs rise except the one leaving SYNC_WAIT, the following updates are registered on the next edge:
  - frame_sig <= acc. Excludes the pixel sampled with the rise; that pixel seeds the new acc.
  - lines <= hs count.
  - frame_count++ (saturating).
  - frame_valid = 1 for one cycle.
- Latency: frame_valid is high 3 clk edges after vs reaches its active level at the input.
- Simultaneous hs and vs rise: the hs rise is counted in the new frame (hs count = 1). Its line check is still performed.
- err bits are sticky until rst. locked is 1 only in LOCKED.
- Reset mid-frame: immediate return to reset values. The first partial frame is never published.

Test Plan:
- Ideal model (1344x806, hs 136, vs 6 lines, rgb = 12'hFFF constant) for 3 frames:
  - frame_valid on 2nd and 3rd vs rise.
  - frame_sig = 16'h7880, lines = 806, line_len = 1344.
  - locked rises at 2nd vs rise; err = 0; frame_count = 2.
- Same timing with rgb = 0: frame_sig = 16'h0000 each frame.
- One line shortened to 1343 clocks in locked frame 3:
  - err[0] = 1, locked = 0 on the next clock.
  - locked returns 1 at the end of the next clean frame; err[0] stays 1.
- Frame with 805 lines: err[2] = 1, lines = 805, locked drops.
- hs width 135 on one line → err[1]. vs 5 lines → err[3].
- rst asserted mid-frame while locked:
  - All outputs 0 immediately.
  - After release, no frame_valid until the 2nd vs rise.
  - frame_count restarts at 1.
